proc_control_fsm: RTL and testbench

PROC_CONTROL_FSM -- requirements
Module: proc_control_fsm

---
 rtl/proc_pkg.sv | 31 +++
 rtl/reg_sel_decoder.sv | 27 ++
 rtl/proc_control_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_proc_control_fsm.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// ----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the processor control FSM: opcode values, ALU
// operation encodings driven on AddXor, and the step-state enumeration.
// Configuration macro: PROC_SUB_EN (consumed by proc_control_fsm; it decides
// whether OP_SUB is executed or retired as illegal).
// ----------------------------------------------------------------------------
package proc_pkg;

    // Opcode values carried in the func field (MSBs of the instruction word)
    localparam int OP_MV  = 0;
    localparam int OP_MVI = 1;
    localparam int OP_ADD = 3;
    localparam int OP_XOR = 4;
    localparam int OP_SUB = 5;

    // AddXor encodings; IDLE is what the ALU sees whenever it is not computing
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_XOR  = 2'b01;
    localparam logic [1:0] ALU_IDLE = 2'b10;
    localparam logic [1:0] ALU_SUB  = 2'b11;

    // Instruction step states; T0 is the idle/fetch state
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage : proc_pkg

// File: rtl/reg_sel_decoder.sv
// ----------------------------------------------------------------------------
// reg_sel_decoder
// Binary register index to one-hot enable decoder with a global enable.
// With i_en low the output is all zeros, so at most one bit is ever set.
//
// Ports:
//   i_en      in   1         decoder enable
//   i_sel     in   SEL_W     register index
//   o_onehot  out  NUM_REGS  one-hot register enable
// ----------------------------------------------------------------------------
module reg_sel_decoder #(
    parameter  int NUM_REGS = 16,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                i_en,
    input  logic [SEL_W-1:0]    i_sel,
    output logic [NUM_REGS-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            o_onehot[i] = i_en && (i_sel == SEL_W'(i));
        end
    end

endmodule : reg_sel_decoder

// File: rtl/proc_control_fsm.sv
// ----------------------------------------------------------------------------
// proc_control_fsm
// Control unit of a simple bus-based processor. An instruction {func, rx, ry}
// is latched into IR on acceptance in T0, then sequenced through T1..T3.
// MV/MVI/illegal opcodes finish in T1; ADD/XOR(/SUB) take T1..T3.
// All outputs are Moore outputs decoded from the state and IR.
//
// Configuration macro: PROC_SUB_EN
//   defined   : func 5 executes SUB (AddXor = 2'b11 in T2)
//   undefined : func 5 is retired as illegal; AddXor never shows 2'b11
//
// Ports:
//   Clock    in   1         rising-edge clock
//   Resetn   in   1         asynchronous active-low reset
//   Run      in   1         start request, sampled only in T0
//   Instr    in   INSTR_W   instruction word {func, rx, ry}
//   R_in     out  NUM_REGS  one-hot register write enable
//   R_out    out  NUM_REGS  one-hot register bus-drive enable
//   Extern   out  1         drive external data onto the bus
//   A_in     out  1         ALU operand latch enable
//   G_in     out  1         ALU result latch enable
//   G_out    out  1         ALU result bus-drive enable
//   AddXor   out  2         ALU op select (00 add, 01 xor, 11 sub, 10 idle)
//   Done     out  1         pulse in the last step of an instruction
//   Busy     out  1         high in T1..T3
//   Illegal  out  1         pulse when an unsupported opcode retires
// ----------------------------------------------------------------------------
module proc_control_fsm
    import proc_pkg::*;
#(
    parameter  int NUM_REGS = 16,
    parameter  int FUNC_W   = 4,
    localparam int SEL_W    = $clog2(NUM_REGS),
    localparam int INSTR_W  = FUNC_W + 2*SEL_W
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Run,
    input  logic [INSTR_W-1:0]  Instr,
    output logic [NUM_REGS-1:0] R_in,
    output logic [NUM_REGS-1:0] R_out,
    output logic                Extern,
    output logic                A_in,
    output logic                G_in,
    output logic                G_out,
    output logic [1:0]          AddXor,
    output logic                Done,
    output logic                Busy,
    output logic                Illegal
);

    state_t               r_state;
    state_t               w_nextState;
    logic [INSTR_W-1:0]   r_ir;

    logic [FUNC_W-1:0]    w_func;
    logic [SEL_W-1:0]     w_rx;
    logic [SEL_W-1:0]     w_ry;

    logic                 w_isMv;
    logic                 w_isMvi;
    logic                 w_isAdd;
    logic                 w_isXor;
    logic                 w_isSub;
    logic                 w_isAlu;
    logic [1:0]           w_aluCode;

    logic                 w_rinEn;
    logic                 w_routEn;
    logic [SEL_W-1:0]     w_routSel;

    // IR field split
    assign w_func = r_ir[INSTR_W-1 -: FUNC_W];
    assign w_rx   = r_ir[2*SEL_W-1 -: SEL_W];
    assign w_ry   = r_ir[SEL_W-1:0];

    // Opcode classification from the latched IR only
    assign w_isMv  = (w_func == FUNC_W'(OP_MV));
    assign w_isMvi = (w_func == FUNC_W'(OP_MVI));
    assign w_isAdd = (w_func == FUNC_W'(OP_ADD));
    assign w_isXor = (w_func == FUNC_W'(OP_XOR));
`ifdef PROC_SUB_EN
    assign w_isSub = (w_func == FUNC_W'(OP_SUB));
`else
    // SUB unsupported in this build: func 5 falls through to illegal
    assign w_isSub = 1'b0;
`endif
    assign w_isAlu = w_isAdd || w_isXor || w_isSub;

    assign w_aluCode = w_isXor ? ALU_XOR :
                       w_isSub ? ALU_SUB : ALU_ADD;

    // State register; reset drops straight back to idle, aborting any
    // instruction in flight before it can reach its write step
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= T0;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Instruction register: loaded only on acceptance, so Instr changes
    // while busy are invisible
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_ir <= '0;
        end else if ((r_state == T0) && Run) begin
            r_ir <= Instr;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        w_nextState = r_state;
        w_rinEn     = 1'b0;
        w_routEn    = 1'b0;
        w_routSel   = w_ry;
        Extern      = 1'b0;
        A_in        = 1'b0;
        G_in        = 1'b0;
        G_out       = 1'b0;
        AddXor      = ALU_IDLE;
        Done        = 1'b0;
        Illegal     = 1'b0;

        case (r_state)
            T0: begin
                if (Run) begin
                    w_nextState = T1;
                end
            end

            T1: begin
                if (w_isMv) begin
                    w_routEn    = 1'b1;
                    w_routSel   = w_ry;
                    w_rinEn     = 1'b1;
                    Done        = 1'b1;
                    w_nextState = T0;
                end else if (w_isMvi) begin
                    Extern      = 1'b1;
                    w_rinEn     = 1'b1;
                    Done        = 1'b1;
                    w_nextState = T0;
                end else if (w_isAlu) begin
                    // First operand (rx) goes into the A latch
                    w_routEn    = 1'b1;
                    w_routSel   = w_rx;
                    A_in        = 1'b1;
                    w_nextState = T2;
                end else begin
                    Done        = 1'b1;
                    Illegal     = 1'b1;
                    w_nextState = T0;
                end
            end

            T2: begin
                // Second operand (ry) on the bus, result captured in G
                w_routEn    = 1'b1;
                w_routSel   = w_ry;
                G_in        = 1'b1;
                AddXor      = w_aluCode;
                w_nextState = T3;
            end

            T3: begin
                G_out       = 1'b1;
                w_rinEn     = 1'b1;
                Done        = 1'b1;
                w_nextState = T0;
            end

            default: begin
                w_nextState = T0;
            end
        endcase
    end

    assign Busy = (r_state != T0);

    // Destination register is always rx
    reg_sel_decoder #(
        .NUM_REGS (NUM_REGS)
    ) u_rinDecoder (
        .i_en     (w_rinEn),
        .i_sel    (w_rx),
        .o_onehot (R_in)
    );

    reg_sel_decoder #(
        .NUM_REGS (NUM_REGS)
    ) u_routDecoder (
        .i_en     (w_routEn),
        .i_sel    (w_routSel),
        .o_onehot (R_out)
    );

endmodule : proc_control_fsm

// File: tb/tb_proc_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_proc_control_fsm
// Directed scoreboard bench for proc_control_fsm (default 16 registers,
// 12-bit instructions). Stimulus pushes cycle-stamped expected output sets
// into a queue; a monitor pops and compares them after each falling edge.
// Honours PROC_SUB_EN to pick the expected func 5 behaviour.
// ----------------------------------------------------------------------------
module tb_proc_control_fsm;

    typedef struct packed {
        logic [15:0] rIn;
        logic [15:0] rOut;
        logic        ext;
        logic        aIn;
        logic        gIn;
        logic        gOut;
        logic [1:0]  addXor;
        logic        done;
        logic        busy;
        logic        illegal;
    } outs_t;

    typedef struct {
        int    cyc;
        string name;
        outs_t exp;
    } entry_t;

    logic        clock;
    logic        resetn;
    logic        run;
    logic [11:0] instr;
    logic [15:0] rIn;
    logic [15:0] rOut;
    logic        ext;
    logic        aIn;
    logic        gIn;
    logic        gOut;
    logic [1:0]  addXor;
    logic        done;
    logic        busy;
    logic        illegal;

    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    entry_t      sbQ[$];

    proc_control_fsm #(
        .NUM_REGS (16),
        .FUNC_W   (4)
    ) dut (
        .Clock   (clock),
        .Resetn  (resetn),
        .Run     (run),
        .Instr   (instr),
        .R_in    (rIn),
        .R_out   (rOut),
        .Extern  (ext),
        .A_in    (aIn),
        .G_in    (gIn),
        .G_out   (gOut),
        .AddXor  (addXor),
        .Done    (done),
        .Busy    (busy),
        .Illegal (illegal)
    );

    // 10 time-unit clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle stamp used to line expectations up with DUT steps
    always @(posedge clock) cyc <= cyc + 1;

    function automatic outs_t mk(logic [15:0] r_i, logic [15:0] r_o,
                                 logic e, logic a, logic gi, logic go,
                                 logic [1:0] op, logic d, logic b, logic il);
        outs_t o;
        o.rIn = r_i;  o.rOut = r_o;  o.ext = e;   o.aIn = a;
        o.gIn = gi;   o.gOut = go;   o.addXor = op;
        o.done = d;   o.busy = b;    o.illegal = il;
        return o;
    endfunction

    function automatic outs_t idleExp();
        return mk(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic pushExp(input int c, input string nm, input outs_t e);
        entry_t en;
        en.cyc  = c;
        en.name = nm;
        en.exp  = e;
        sbQ.push_back(en);
    endtask

    // Compare present DUT outputs against one expected set
    task automatic checkOutput(input string nm, input outs_t e);
        outs_t act;
        act = {rIn, rOut, ext, aIn, gIn, gOut, addXor, done, busy, illegal};
        checks++;
        if (act !== e) begin
            errors++;
            $display("[TB] FAIL %s @cyc %0d: got rIn=%h rOut=%h ext=%b aIn=%b gIn=%b gOut=%b op=%b done=%b busy=%b ill=%b, want rIn=%h rOut=%h ext=%b aIn=%b gIn=%b gOut=%b op=%b done=%b busy=%b ill=%b",
                     nm, cyc, act.rIn, act.rOut, act.ext, act.aIn, act.gIn, act.gOut,
                     act.addXor, act.done, act.busy, act.illegal,
                     e.rIn, e.rOut, e.ext, e.aIn, e.gIn, e.gOut,
                     e.addXor, e.done, e.busy, e.illegal);
        end
    endtask

    // Drive inputs on a falling edge; returns the cycle stamp at drive time,
    // so the step after the next rising edge carries stamp c+1
    task automatic applyStimulus(input logic [11:0] ins, input logic r, output int c);
        @(negedge clock);
        run   = r;
        instr = ins;
        c     = cyc;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: pops every expectation whose stamp has come due
    initial begin
        entry_t en;
        forever begin
            @(negedge clock);
            #1;
            while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
                en = sbQ.pop_front();
                if (en.cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL %s: expectation for cyc %0d missed at cyc %0d",
                             en.name, en.cyc, cyc);
                end else begin
                    checkOutput(en.name, en.exp);
                end
            end
        end
    end

    initial begin
        int c;
        int c2;
        int wait_n;

        resetn = 1'b0;
        run    = 1'b0;
        instr  = 12'h000;

        // Reset values while reset is held
        #3;
        checkOutput("reset_values", idleExp());
        @(negedge clock);
        #2 resetn = 1'b1;

        // MV R3,R5
        applyStimulus(12'h035, 1'b1, c);
        pushExp(c + 1, "mv_t1",   mk(16'h0008, 16'h0020, 0, 0, 0, 0, 2'b10, 1, 1, 0));
        pushExp(c + 2, "mv_idle", idleExp());
        applyStimulus(12'h035, 1'b0, c2);
        waitCycles(2);

        // MVI R7
        applyStimulus(12'h170, 1'b1, c);
        pushExp(c + 1, "mvi_t1",   mk(16'h0080, 16'h0000, 1, 0, 0, 0, 2'b10, 1, 1, 0));
        pushExp(c + 2, "mvi_idle", idleExp());
        applyStimulus(12'h170, 1'b0, c2);
        waitCycles(2);

        // ADD R1,R2 with Instr scrambled once accepted
        applyStimulus(12'h312, 1'b1, c);
        pushExp(c + 1, "add_t1",   mk(16'h0000, 16'h0002, 0, 1, 0, 0, 2'b10, 0, 1, 0));
        pushExp(c + 2, "add_t2",   mk(16'h0000, 16'h0004, 0, 0, 1, 0, 2'b00, 0, 1, 0));
        pushExp(c + 3, "add_t3",   mk(16'h0002, 16'h0000, 0, 0, 0, 1, 2'b10, 1, 1, 0));
        pushExp(c + 4, "add_idle", idleExp());
        applyStimulus(12'hFFF, 1'b0, c2);
        waitCycles(4);

        // func 5: SUB or illegal depending on build
        applyStimulus(12'h512, 1'b1, c);
`ifdef PROC_SUB_EN
        pushExp(c + 1, "sub_t1",   mk(16'h0000, 16'h0002, 0, 1, 0, 0, 2'b10, 0, 1, 0));
        pushExp(c + 2, "sub_t2",   mk(16'h0000, 16'h0004, 0, 0, 1, 0, 2'b11, 0, 1, 0));
        pushExp(c + 3, "sub_t3",   mk(16'h0002, 16'h0000, 0, 0, 0, 1, 2'b10, 1, 1, 0));
        pushExp(c + 4, "sub_idle", idleExp());
`else
        pushExp(c + 1, "sub_illegal_t1", mk(16'h0000, 16'h0000, 0, 0, 0, 0, 2'b10, 1, 1, 1));
        pushExp(c + 2, "sub_illegal_idle", idleExp());
`endif
        applyStimulus(12'h512, 1'b0, c2);
        waitCycles(4);

        // func 2 is always illegal
        applyStimulus(12'h2AB, 1'b1, c);
        pushExp(c + 1, "illegal_t1",   mk(16'h0000, 16'h0000, 0, 0, 0, 0, 2'b10, 1, 1, 1));
        pushExp(c + 2, "illegal_idle", idleExp());
        applyStimulus(12'h2AB, 1'b0, c2);
        waitCycles(2);

        // XOR R3,R3 (rx == ry)
        applyStimulus(12'h433, 1'b1, c);
        pushExp(c + 1, "xorsame_t1", mk(16'h0000, 16'h0008, 0, 1, 0, 0, 2'b10, 0, 1, 0));
        pushExp(c + 2, "xorsame_t2", mk(16'h0000, 16'h0008, 0, 0, 1, 0, 2'b01, 0, 1, 0));
        pushExp(c + 3, "xorsame_t3", mk(16'h0008, 16'h0000, 0, 0, 0, 1, 2'b10, 1, 1, 0));
        pushExp(c + 4, "xorsame_idle", idleExp());
        applyStimulus(12'h433, 1'b0, c2);
        waitCycles(4);

        // Back-to-back XORs with Run held high; Done at c+3 and c+7
        applyStimulus(12'h412, 1'b1, c);
        pushExp(c + 1, "b2b_a_t1", mk(16'h0000, 16'h0002, 0, 1, 0, 0, 2'b10, 0, 1, 0));
        pushExp(c + 2, "b2b_a_t2", mk(16'h0000, 16'h0004, 0, 0, 1, 0, 2'b01, 0, 1, 0));
        pushExp(c + 3, "b2b_a_t3", mk(16'h0002, 16'h0000, 0, 0, 0, 1, 2'b10, 1, 1, 0));
        pushExp(c + 4, "b2b_gap",  idleExp());
        pushExp(c + 5, "b2b_b_t1", mk(16'h0000, 16'h0010, 0, 1, 0, 0, 2'b10, 0, 1, 0));
        pushExp(c + 6, "b2b_b_t2", mk(16'h0000, 16'h0020, 0, 0, 1, 0, 2'b01, 0, 1, 0));
        pushExp(c + 7, "b2b_b_t3", mk(16'h0010, 16'h0000, 0, 0, 0, 1, 2'b10, 1, 1, 0));
        pushExp(c + 8, "b2b_idle", idleExp());
        applyStimulus(12'h0FF, 1'b1, c2);
        applyStimulus(12'h2AB, 1'b1, c2);
        applyStimulus(12'h445, 1'b1, c2);
        applyStimulus(12'h445, 1'b1, c2);
        applyStimulus(12'h1FF, 1'b1, c2);
        applyStimulus(12'h1FF, 1'b1, c2);
        applyStimulus(12'h1FF, 1'b0, c2);
        waitCycles(2);

        // Reset pulsed in T2 of an ADD, then a plain MV
        applyStimulus(12'h312, 1'b1, c);
        pushExp(c + 1, "rst_add_t1", mk(16'h0000, 16'h0002, 0, 1, 0, 0, 2'b10, 0, 1, 0));
        pushExp(c + 2, "rst_add_t2", mk(16'h0000, 16'h0004, 0, 0, 1, 0, 2'b00, 0, 1, 0));
        pushExp(c + 3, "rst_no_t3",  idleExp());
        pushExp(c + 4, "rst_idle",   idleExp());
        applyStimulus(12'h312, 1'b0, c2);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1 checkOutput("rst_immediate", idleExp());
        @(negedge clock);
        #2 resetn = 1'b1;
        applyStimulus(12'h035, 1'b1, c);
        pushExp(c + 1, "post_rst_mv_t1", mk(16'h0008, 16'h0020, 0, 0, 0, 0, 2'b10, 1, 1, 0));
        pushExp(c + 2, "post_rst_idle",  idleExp());
        applyStimulus(12'h035, 1'b0, c2);

        // Drain scoreboard with a bounded wait
        wait_n = 0;
        while (sbQ.size() > 0 && wait_n < 50) begin
            @(negedge clock);
            wait_n++;
        end
        #2;
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sbQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_proc_control_fsm
